// File: rtl/display_pkg.sv
// Shared display definitions: FSM states, blanking constants and the hex glyph table.
package display_pkg;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for 0-F, lowercase b and d
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/result_display.sv
// Pages a captured 64-bit result across a 4-digit multiplexed seven-segment display.
// Optional last-page blinking is enabled by defining RESULT_DISPLAY_BLINK_EN.
module result_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] result,
  input  logic [1:0]  size_sel,
  input  logic        next,
  output logic        busy,
  output logic [1:0]  page,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (REFRESH_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
    $error("result_display: REFRESH_DIV and BLINK_DIV must be >= 1");
  end

  state_t      state;
  logic [63:0] res_q;
  logic [1:0]  last_q;
  logic [RW-1:0] refresh_cnt;
  logic [1:0]  idx;
  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic        blink_blank;

  // Page FSM plus the refresh counter; counters hold at zero while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      page        <= 2'd0;
      res_q       <= 64'd0;
      last_q      <= 2'd0;
      refresh_cnt <= '0;
      idx         <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          refresh_cnt <= '0;
          idx         <= 2'd0;
          if (load) begin
            res_q  <= result;
            last_q <= size_sel;
            page   <= 2'd0;
            busy   <= 1'b1;
            state  <= SHOW;
          end
        end
        SHOW: begin
          if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
          end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
          end
          if (next) begin
            if (page == last_q) begin
              state       <= IDLE;
              busy        <= 1'b0;
              page        <= 2'd0;
              refresh_cnt <= '0;
              idx         <= 2'd0;
            end else begin
              page <= page + 2'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          page  <= 2'd0;
        end
      endcase
    end
  end

`ifdef RESULT_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Blink timebase restarts from zero every time a new result is shown
  always_ff @(posedge clk) begin
    if (rst || state != SHOW) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blink_blank = (state == SHOW) && (page == last_q) && blink_phase;
`else
  assign blink_blank = 1'b0;
`endif

  assign nibble = res_q[{page, idx, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble(nibble),
    .seg   (glyph)
  );

  // The lit decimal point marks which page is on screen
  always_comb begin
    an  = AN_OFF;
    seg = SEG_BLANK;
    dp  = 1'b1;
    if (state == SHOW) begin
      an  = digit_enable(idx);
      seg = glyph;
      dp  = (idx == page) ? 1'b0 : 1'b1;
      if (blink_blank) begin
        an = AN_OFF;
        dp = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Scoreboard testbench for result_display: driver pushes model predictions, monitor compares.
module tb_result_display;

  localparam int RD = 2;
  localparam int BD = 8;
`ifdef RESULT_DISPLAY_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic [1:0] page;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, load, next;
  logic [63:0] result;
  logic [1:0]  size_sel;
  logic        busy;
  logic [1:0]  page;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  exp_t expq[$];
  int   checks = 0;
  int   passes = 0;
  int   cycle  = 0;

  // Independent glyph table: hex digit -> active-low {g..a}
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: "showing a value of npages words, t cycles after it appeared"
  bit          m_show = 0;
  logic [63:0] m_val  = '0;
  int          m_npages = 1;
  int          m_page = 0;
  int          m_t = 0;

  always #5 clk = ~clk;

  result_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .load(load), .result(result), .size_sel(size_sel),
    .next(next), .busy(busy), .page(page), .an(an), .seg(seg), .dp(dp)
  );

  task automatic applyStimulus(input logic r, input logic l, input logic [63:0] v,
                               input logic [1:0] s, input logic n);
    exp_t e;
    int   d;
    @(negedge clk);
    rst = r; load = l; result = v; size_sel = s; next = n;
    cycle++;
    if (r) begin
      m_show = 0;
      m_page = 0;
    end else if (!m_show) begin
      if (l) begin
        m_show = 1; m_val = v; m_npages = int'(s) + 1; m_page = 0; m_t = 0;
      end
    end else begin
      m_t++;
      if (n) begin
        if (m_page == m_npages - 1) begin
          m_show = 0;
          m_page = 0;
        end else begin
          m_page++;
        end
      end
    end
    e.cyc = cycle;
    if (!m_show) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.busy = 1'b0; e.page = 2'd0;
    end else begin
      d = (m_t / RD) % 4;
      e.an   = 4'hF & ~(4'(1) << d);
      e.seg  = glyph[4'((m_val >> (16 * m_page + 4 * d)) & 64'hF)];
      e.dp   = (d == m_page) ? 1'b0 : 1'b1;
      e.busy = 1'b1;
      e.page = 2'(m_page);
      if (BLINK && m_page == m_npages - 1 && ((m_t / BD) % 2) == 1) begin
        e.an = 4'hF;
        e.dp = 1'b1;
      end
    end
    expq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic [7:0] act,
                             input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // Monitor: one DUT output sample per cycle, shortly after the active edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checkOutput("busy", e.cyc, {7'd0, busy}, {7'd0, e.busy});
      checkOutput("page", e.cyc, {6'd0, page}, {6'd0, e.page});
      checkOutput("an",   e.cyc, {4'd0, an},   {4'd0, e.an});
      checkOutput("seg",  e.cyc, {1'b0, seg},  {1'b0, e.seg});
      checkOutput("dp",   e.cyc, {7'd0, dp},   {7'd0, e.dp});
    end
  end

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, 64'd0, 2'd0, 1'b0);
  endtask

  initial begin
    logic [63:0] pat;
    int wait_cnt;
    pat = 64'h0123_4567_89AB_CDEF;
    rst = 1'b1; load = 1'b0; next = 1'b0; result = '0; size_sel = '0;

    applyStimulus(1'b1, 1'b0, 64'd0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'd0, 2'd0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 64'd0, 2'd0, 1'b1);

    // Single page, sweep then dismiss
    applyStimulus(1'b0, 1'b1, pat, 2'b00, 1'b0);
    idleCycles(20);
    applyStimulus(1'b0, 1'b0, 64'd0, 2'd0, 1'b1);
    idleCycles(3);

    // Four, then three pages
    for (int sz = 3; sz >= 2; sz--) begin
      applyStimulus(1'b0, 1'b1, pat, 2'(sz), 1'b0);
      for (int p = 0; p <= sz; p++) begin
        idleCycles(9);
        applyStimulus(1'b0, 1'b0, 64'd0, 2'd0, 1'b1);
      end
      idleCycles(2);
    end

    // load ignored while showing; load+next in idle
    applyStimulus(1'b0, 1'b1, pat, 2'b01, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0);
    idleCycles(8);
    applyStimulus(1'b0, 1'b0, 64'd0, 2'd0, 1'b1);
    idleCycles(20);
    applyStimulus(1'b0, 1'b0, 64'd0, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 64'h1111_2222_3333_4444, 2'b00, 1'b1);
    idleCycles(5);

    // Reset while showing
    applyStimulus(1'b1, 1'b0, 64'd0, 2'd0, 1'b0);
    idleCycles(2);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 7) == 0),
                    {$urandom, $urandom},
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 11) == 0));
    end

    wait_cnt = 0;
    while (expq.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    checks++;
    if (expq.size() == 0) passes++;
    else $display("[TB] FAIL drain: got %0d pending, expected 0", expq.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Output-side counterpart to the switch/button operand-entry front end.
- Takes a completed 64-bit result and its operand size, and presents it on a 4-digit multiplexed seven-segment display, 16 bits (4 hex digits) per page.
- The user steps through pages with the debounced push-button pulse.
- Sits between the top-level result register and the board's display pins; the FSM moves to the next menu only when this block drops busy.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is driven before the digit mux advances (must be >= 1).
- BLINK_DIV, 25000000, clk cycles per blink half-period (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- load  in  1  single-cycle pulse: capture result and size_sel
- result  in  64  value to display
- size_sel  in  2  operand size: 00 = 16-bit, 01 = 32-bit, 10 = 48-bit, 11 = 64-bit
- next  in  1  single-cycle debounced button pulse: advance page
- busy  out  1  high while a result is being displayed
- page  out  2  index of the 16-bit word currently shown
- an  out  4  digit enables, active-low, one-hot
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset (synchronous, active-high) values:
  - busy=0, page=0, an=4'b1111, seg=7'b1111111, dp=1.
  - State=IDLE, refresh counter=0, digit index=0, captured registers cleared.
- States:
  - IDLE: display blanked (an=1111, seg=1111111, dp=1); busy=0.
    - load=1 → capture result into res_q and size_sel into last_q; page=0; next cycle state=SHOW, busy=1.
  - SHOW: busy=1; shows res_q[16*page+15 : 16*page].
    - next=1 with page<last_q → page=page+1.
    - next=1 with page==last_q → state=IDLE, busy=0, page=0, display blanked the following cycle.
- Latency: busy rises and the first digit is driven on the cycle after load. A page change is visible on the cycle after next.
- Simultaneous events and ignored inputs:
  - load while in SHOW is ignored; res_q is not overwritten.
  - load and next in the same IDLE cycle: load wins, next is ignored.
  - next in IDLE is ignored.
- Digit mux (SHOW only):
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index increments modulo 4 (3→0).
  - an = ~(4'b0001 << idx); idx 0 is the least significant nibble.
  - seg = hex_to_seg(nibble[idx]); 0–F use the standard hex glyphs (lowercase b and d).
  - In IDLE the counters hold at 0.
- dp: low (lit) only on the digit whose idx equals page, so the user can see which page is shown.
- Reset mid-display: returns to IDLE blanked in one cycle, regardless of page or counters.

Optional Feature:
- RESULT_DISPLAY_BLINK_EN defined:
  - A blink counter runs in SHOW, toggling a blink phase every BLINK_DIV cycles.
  - While page==last_q and blink phase=1, an=1111 (digits blanked); dp follows an.
  - Blink counter and phase reset to 0 on entering SHOW.
- Not defined: no blink counter exists; the last page is displayed steadily like every other page.

Decomposition:
- Shared package (display_pkg):
  - State enum {IDLE, SHOW}.
  - Constant SEG_BLANK=7'h7F.
  - Constant AN_OFF=4'hF.
  - The 16-entry hex glyph table.
- Sub-module hex_to_seg: combinational 4-bit nibble → 7-bit active-low pattern. Reused by any future display block.

Test Plan (REFRESH_DIV=2, BLINK_DIV=8 in the bench):
- Reset → an=1111, seg=1111111, dp=1, busy=0, page=0. Assert rst in SHOW → same values one cycle later.
- load with result=64'h0123_4567_89AB_CDEF, size_sel=00 → busy=1 next cycle. The digit sweep shows F,E,D,C (seg 0001110, 0000110, 0100001, 1000110) with an cycling 1110,1101,1011,0111 every 2 cycles; dp low only on idx 0. One next → busy=0 and display blank.
- Same result, size_sel=11 → three next pulses give page 1,2,3 with digits 89AB, 4567, 0123; dp moves to idx 1,2,3. Fourth next → IDLE.
- size_sel=10 → exactly 3 pages, 2 next pulses keep busy=1, third next → busy=0.
- load pulsed in SHOW with result=64'hFFFF… → displayed digits unchanged. load+next in the same IDLE cycle → SHOW, page=0.
- With RESULT_DISPLAY_BLINK_EN, size_sel=00 → an=1111 for 8 cycles alternating with the normal sweep. Without the macro → no blank intervals.
